// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - single-outstanding instruction fetch unit with {pc, inst} queue
//
// Purpose:
//   Samples the PC register's tri-state Q bus, issues one instruction-memory
//   read at a time and queues {pc, instruction} pairs for decode. The returned
//   pc_advance strobe is the PC register's ClockEnable. A redirect flushes the
//   queue and abandons any in-flight read.
//
// Ports:
//   Clock, Reset          rising-edge clock, asynchronous active-high reset
//   pc_in, pc_cs          PC bus value; pc_cs=1 means the bus is not driven
//   redirect              branch/jump taken: flush queue, drop in-flight fetch
//   pc_advance            PC register ClockEnable (one pulse per accepted fetch)
//   mem_req, mem_addr     instruction memory read request and address
//   mem_ack, mem_rdata    memory response strobe and instruction word
//   out_valid, out_inst,
//   out_pc, out_ready     head of queue towards decode, popped on valid & ready
module inst_fetch_queue #(
  parameter int AddrBits = 32,
  parameter int DataBits = 32,
  parameter int Depth    = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [AddrBits-1:0] pc_in,
  input  logic                pc_cs,
  input  logic                redirect,
  output logic                pc_advance,
  output logic                mem_req,
  output logic [AddrBits-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [DataBits-1:0] mem_rdata,
  output logic                out_valid,
  output logic [DataBits-1:0] out_inst,
  output logic [AddrBits-1:0] out_pc,
  input  logic                out_ready
);

  localparam int PtrBits = $clog2(Depth);
  localparam int CntBits = PtrBits + 1;
  localparam logic [CntBits-1:0] DepthCnt = CntBits'(Depth);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e              state_q;
  logic                req_q;
  logic [AddrBits-1:0] addr_q;
  logic [CntBits-1:0]  count_q, count_d;
  logic [PtrBits-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrBits-1:0]  wr_ptr_q, wr_ptr_d;

  logic [AddrBits-1:0] pc_mem   [Depth];
  logic [DataBits-1:0] inst_mem [Depth];

  logic space;
  logic issue;
  logic push;
  logic pop;

  // Room is checked only at issue; since only one read is ever outstanding,
  // the matching push always finds a free slot.
  assign space = (count_q < DepthCnt);
  assign issue = (state_q == IDLE) & ~pc_cs & ~redirect & space;

  assign pc_advance = (state_q == REQ) & mem_ack & ~redirect;
  assign push       = pc_advance;
  assign pop        = out_valid & out_ready & ~redirect;

  assign mem_req  = req_q;
  assign mem_addr = addr_q;

  // Fetch FSM. mem_addr is captured only on issue, so the bus value is never
  // looked at while pc_cs=1 and stays constant for the whole request.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            addr_q  <= pc_in;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            // Ack together with redirect: the word is simply not pushed.
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else if (redirect) begin
            // The memory still owes one ack for this read; swallow it in DROP.
            state_q <= DROP;
            req_q   <= 1'b0;
          end
        end
        DROP: begin
          if (mem_ack) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Queue bookkeeping. Redirect wins over any same-cycle pop.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrBits'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrBits'(1);
      end
      if (push & ~pop) begin
        count_d = count_q + CntBits'(1);
      end else if (pop & ~push) begin
        count_d = count_q - CntBits'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge Clock) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= addr_q;
      inst_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? inst_mem[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;

endmodule
